// File: rtl/bf_async_read_master.sv
// bf_async_read_master: Blackfin async-memory read initiator with programmable
// setup/strobe/hold timing, ARDY extension with timeout, and a one-deep valid/ready output.
module bf_async_read_master #(
  parameter logic [2:0] BANK0_MASK  = 3'h0,
  parameter logic [2:0] BANK1_MASK  = 3'h1,
  parameter int         SETUP_CYC   = 1,
  parameter int         STROBE_CYC  = 2,
  parameter int         HOLD_CYC    = 1,
  parameter bit         ARDY_EN     = 1'b1,
  parameter int         TIMEOUT_CYC = 64
) (
  input  logic        BF_I_clk,
  input  logic        I_rst,
  input  logic        I_start,
  input  logic        I_bank,
  input  logic [12:0] I_startAddr,
  input  logic [13:0] I_len,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_timeout,
  output logic [15:0] BF_O_addr,
  output logic        BF_O_bankSelect,
  output logic        BF_O_are,
  output logic        BF_O_awe,
  input  logic        BF_I_ardy,
  input  logic [15:0] BF_I_dataBus,
  output logic [15:0] O_data,
  output logic        O_dataValid,
  input  logic        I_dataReady
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, STALL, DONE} state_t;
  state_t state, state_n;
  logic        bank, tmo, last, fire, tmo_set, xfer;
  logic [12:0] addr;
  logic [13:0] rem;
  logic [15:0] cnt, wcnt, lim;
  assign xfer = O_dataValid & I_dataReady;
  assign lim = state == SETUP ? 16'(SETUP_CYC - 1) : state == STROBE ? 16'(STROBE_CYC - 1) : 16'(HOLD_CYC - 1);
  assign last = cnt >= lim;
  always_comb begin
    state_n = state;
    fire = 1'b0;
    tmo_set = 1'b0;
    case (state)
      IDLE:   if (I_start) state_n = I_len == 14'd0 ? DONE : SETUP;
      SETUP:  if (last) state_n = STROBE;
      STROBE: if (last) begin
        if (!ARDY_EN || BF_I_ardy) begin
          fire = 1'b1;
          state_n = HOLD;
        end else if (wcnt == 16'(TIMEOUT_CYC)) begin
          tmo_set = 1'b1;
          state_n = DONE;
        end
      end
      HOLD:   if (last) state_n = rem == 14'd0 ? DONE : (O_dataValid && !I_dataReady) ? STALL : SETUP;
      STALL:  if (xfer) state_n = SETUP;
      DONE:   if (!O_dataValid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge BF_I_clk or posedge I_rst) begin
    if (I_rst) begin
      state <= IDLE;
      cnt <= '0;
      wcnt <= '0;
      bank <= 1'b0;
      addr <= '0;
      rem <= '0;
      tmo <= 1'b0;
      O_data <= '0;
      O_dataValid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state_n != state ? 16'd0 : cnt + 16'd1;
      if (state == IDLE && I_start) begin
        bank <= I_bank;
        addr <= I_startAddr;
        rem <= I_len;
        tmo <= 1'b0;
      end
      if (state == SETUP) wcnt <= '0;
      else if (state == STROBE && last && !fire && !tmo_set) wcnt <= wcnt + 16'd1;
      if (fire) begin
        O_data <= BF_I_dataBus;
        rem <= rem - 14'd1;
      end
      O_dataValid <= fire | (O_dataValid & ~I_dataReady);
      if (state == HOLD && last) addr <= addr + 13'd1;
      if (tmo_set) tmo <= 1'b1;
    end
  end
  assign O_busy = state != IDLE;
  assign O_done = state == DONE && !O_dataValid;
  assign O_timeout = O_done & tmo;
  assign BF_O_bankSelect = state == SETUP || state == STROBE || state == HOLD;
  assign BF_O_are = state == STROBE;
  assign BF_O_awe = 1'b0;
  assign BF_O_addr = BF_O_bankSelect ? {bank ? BANK1_MASK : BANK0_MASK, addr} : 16'h0000;
endmodule
